// File: rtl/uart_command_serializer.sv
// uart_command_serializer
// Latches a packed command buffer and its byte count, then streams the bytes
// to a UART TX shifter over a valid/ready handshake. The link terminator is
// appended after the payload: 0x0D on the BLE side, or 0xBE,0xEF on the host side.
// A stalled handshake is aborted after TIMEOUT consecutive stalled cycles.
module uart_command_serializer #(
  parameter int TIMEOUT   = 2000,
  parameter int MAX_BYTES = 128
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1023:0] cmd_data,
  input  logic [7:0]    cmd_size,
  input  logic          ble_side,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          done,
  output logic          error
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND   = 3'd1,
    TERM0  = 3'd2,
    TERM1  = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t          state_reg, state_next;
  logic [7:0]      index_reg, index_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic            error_reg, error_next;
  logic [1023:0]   buf_reg;
  logic [7:0]      size_reg;
  logic            ble_reg;
  logic            load;
  logic [7:0]      buf_bytes [128];
  logic [7:0]      cur_byte;

  // Split the latched buffer into addressable bytes.
  generate
    for (genvar gi = 0; gi < 128; gi++) begin : g_bytes
      assign buf_bytes[gi] = buf_reg[8*gi +: 8];
    end
  endgenerate

  // Index never exceeds 127 while in SEND, so the low 7 bits address the byte.
  assign cur_byte = buf_bytes[index_reg[6:0]];
  assign error    = error_reg;

  // State, counters and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      index_reg <= 8'd0;
      timer_reg <= '0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
      timer_reg <= timer_next;
      error_reg <= error_next;
    end
  end

  // Command latch; only written when a valid start is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_reg  <= '0;
      size_reg <= 8'd0;
      ble_reg  <= 1'b0;
    end else if (load) begin
      buf_reg  <= cmd_data;
      size_reg <= cmd_size;
      ble_reg  <= ble_side;
    end
  end

  // Next-state logic, handshake outputs and stall timeout.
  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    timer_next = timer_reg;
    error_next = error_reg;
    load       = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    done       = 1'b0;

    case (state_reg)
      IDLE: begin
        done       = 1'b1;
        timer_next = '0;
        if (start) begin
          if (cmd_size == 8'd0 || cmd_size > 8'(MAX_BYTES)) begin
            error_next = 1'b1;
          end else begin
            load       = 1'b1;
            error_next = 1'b0;
            index_next = 8'd0;
            state_next = SEND;
          end
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = cur_byte;
        if (tx_ready) begin
          index_next = index_reg + 8'd1;
          if (index_reg + 8'd1 == size_reg) state_next = TERM0;
        end
      end
      TERM0: begin
        tx_valid = 1'b1;
        tx_data  = ble_reg ? 8'h0D : 8'hBE;
        if (tx_ready) state_next = ble_reg ? FINISH : TERM1;
      end
      TERM1: begin
        tx_valid = 1'b1;
        tx_data  = 8'hEF;
        if (tx_ready) state_next = FINISH;
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Any transfer restarts the stall timer; a long stall abandons the command.
    if (tx_valid) begin
      if (tx_ready) begin
        timer_next = '0;
      end else if (timer_reg == TW'(TIMEOUT - 1)) begin
        timer_next = '0;
        state_next = IDLE;
        error_next = 1'b1;
      end else begin
        timer_next = timer_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_command_serializer.sv
// Testbench for uart_command_serializer: table-driven commands checked by a
// byte scoreboard, plus hand sequences for latency, timeout and reset abort.
module tb_uart_command_serializer;

  localparam int TO = 2000;

  logic          clk;
  logic          reset;
  logic          start;
  logic [1023:0] cmd_data;
  logic [7:0]    cmd_size;
  logic          ble_side;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          done;
  logic          error;

  uart_command_serializer #(.TIMEOUT(TO), .MAX_BYTES(128)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .cmd_data (cmd_data),
    .cmd_size (cmd_size),
    .ble_side (ble_side),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  int xfers = 0;
  int ready_mode = 0;   // 0 always, 1 one-in-four, 2 never, 3 random
  logic abort_ok = 1'b0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  typedef struct {
    int         size;
    logic       ble;
    int         mode;
    logic       exp_err;
    logic       all_ff;
    logic [7:0] base;
  } vec_t;

  vec_t vecs [9];

  // tx_ready driver, updated just after each rising edge.
  initial begin
    int cyc;
    cyc = 0;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (ready_mode)
        0: tx_ready = 1'b1;
        1: tx_ready = (cyc % 4 == 0);
        2: tx_ready = 1'b0;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Scoreboard and handshake-stability monitor, sampled on falling edges.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        if (tx_valid) begin
          checks++;
          if (tx_data !== prev_data) begin
            errors++;
            $display("FAIL hold_data: got %02h required %02h", tx_data, prev_data);
          end
        end else if (!abort_ok) begin
          checks++;
          errors++;
          $display("FAIL hold_valid: tx_valid dropped without transfer, required 1");
        end
      end
      if (tx_valid && tx_ready) begin
        xfers++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %02h required none", tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            errors++;
            $display("FAIL byte: got %02h required %02h", tx_data, e);
          end
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic load_cmd(input int size, input logic ble, input logic all_ff, input logic [7:0] base,
                          input logic push);
    logic [1023:0] d;
    d = '0;
    for (int i = 0; i < 128; i++) d[8*i +: 8] = all_ff ? 8'hFF : 8'(base + i);
    cmd_data = d;
    cmd_size = 8'(size);
    ble_side = ble;
    if (push) begin
      for (int i = 0; i < size; i++) exp_q.push_back(all_ff ? 8'hFF : 8'(base + i));
      if (ble) exp_q.push_back(8'h0D);
      else begin
        exp_q.push_back(8'hBE);
        exp_q.push_back(8'hEF);
      end
    end
  endtask

  // One-cycle start pulse; command inputs are scrambled afterwards.
  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cmd_data = {32{$urandom()}};
    cmd_size = 8'($urandom());
    ble_side = 1'($urandom());
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic run_case(input vec_t v, input int idx);
    int x0;
    ready_mode = v.mode;
    load_cmd(v.size, v.ble, v.all_ff, v.base, !v.exp_err);
    x0 = xfers;
    pulse_start();
    @(negedge clk);
    if (v.exp_err) begin
      check("bad_size_error", {31'd0, error}, 32'd1);
      check("bad_size_done", {31'd0, done}, 32'd1);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check("bad_size_no_valid", {31'd0, tx_valid}, 32'd0);
      end
    end else begin
      wait_done(20 * v.size + 100);
      check("case_error", {31'd0, error}, 32'd0);
      check("case_queue_empty", exp_q.size(), 32'd0);
      check("case_xfer_count", xfers - x0, v.size + (v.ble ? 1 : 2));
    end
    $display("vector %0d size=%0d ble=%0d mode=%0d transfers=%0d error=%0d",
             idx, v.size, v.ble, v.mode, xfers - x0, error);
    exp_q.delete();
  endtask

  initial begin
    int cnt;
    vecs[0] = '{size: 3,   ble: 1'b1, mode: 0, exp_err: 1'b0, all_ff: 1'b0, base: 8'h41};
    vecs[1] = '{size: 2,   ble: 1'b0, mode: 0, exp_err: 1'b0, all_ff: 1'b0, base: 8'h01};
    vecs[2] = '{size: 5,   ble: 1'b1, mode: 1, exp_err: 1'b0, all_ff: 1'b0, base: 8'h10};
    vecs[3] = '{size: 0,   ble: 1'b1, mode: 0, exp_err: 1'b1, all_ff: 1'b0, base: 8'h00};
    vecs[4] = '{size: 129, ble: 1'b0, mode: 0, exp_err: 1'b1, all_ff: 1'b0, base: 8'h00};
    vecs[5] = '{size: 128, ble: 1'b0, mode: 0, exp_err: 1'b0, all_ff: 1'b1, base: 8'h00};
    vecs[6] = '{size: 7,   ble: 1'b0, mode: 3, exp_err: 1'b0, all_ff: 1'b0, base: 8'hA0};
    vecs[7] = '{size: 1,   ble: 1'b1, mode: 1, exp_err: 1'b0, all_ff: 1'b0, base: 8'h55};
    vecs[8] = '{size: 128, ble: 1'b1, mode: 3, exp_err: 1'b0, all_ff: 1'b0, base: 8'h00};

    start = 1'b0;
    cmd_data = '0;
    cmd_size = 8'd0;
    ble_side = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("reset_tx_data", {24'd0, tx_data}, 32'h00);
    check("reset_done", {31'd0, done}, 32'd1);
    check("reset_error", {31'd0, error}, 32'd0);
    reset = 1'b0;

    // Latency and done timing: BLE, 41 42 43, ready always high.
    ready_mode = 0;
    load_cmd(3, 1'b1, 1'b0, 8'h41, 1'b1);
    pulse_start();
    @(negedge clk);
    check("latency_valid", {31'd0, tx_valid}, 32'd1);
    check("latency_data", {24'd0, tx_data}, 32'h41);
    check("busy_done", {31'd0, done}, 32'd0);
    repeat (4) @(negedge clk);
    check("finish_valid", {31'd0, tx_valid}, 32'd0);
    check("finish_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("idle_done", {31'd0, done}, 32'd1);
    check("latency_queue_empty", exp_q.size(), 32'd0);
    $display("latency sequence done=%0d error=%0d", done, error);

    for (int i = 0; i < 9; i++) run_case(vecs[i], i);

    // Timeout: tx_ready held low after the first byte is offered.
    ready_mode = 2;
    @(negedge clk);
    load_cmd(4, 1'b0, 1'b0, 8'h30, 1'b0);
    abort_ok = 1'b1;
    pulse_start();
    cnt = 0;
    for (int i = 0; i < TO + 10; i++) begin
      @(negedge clk);
      if (tx_valid) cnt++;
      else break;
    end
    check("timeout_valid_cycles", cnt, TO);
    check("timeout_valid_low", {31'd0, tx_valid}, 32'd0);
    check("timeout_error", {31'd0, error}, 32'd1);
    check("timeout_done", {31'd0, done}, 32'd1);
    repeat (3) @(negedge clk);
    check("timeout_error_sticky", {31'd0, error}, 32'd1);
    abort_ok = 1'b0;
    $display("timeout sequence valid_cycles=%0d error=%0d", cnt, error);
    run_case(vecs[1], 9);

    // Reset mid-stream: 128 x FF host side.
    ready_mode = 0;
    load_cmd(128, 1'b0, 1'b1, 8'h00, 1'b1);
    pulse_start();
    repeat (40) @(negedge clk);
    @(posedge clk);
    #1;
    abort_ok = 1'b1;
    reset = 1'b1;
    #1;
    check("midreset_valid", {31'd0, tx_valid}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    abort_ok = 1'b0;
    repeat (5) @(negedge clk);
    check("after_reset_valid", {31'd0, tx_valid}, 32'd0);
    $display("reset sequence valid=%0d done=%0d", tx_valid, done);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
